div_control: RTL and testbench

DIV_CONTROL -- requirements
Module: div_control

---
 rtl/div_pkg.sv | 32 +++
 rtl/div_range_check.sv | 33 +++
 rtl/div_control.sv | 188 ++++++++++++++++++
 tb/tb_div_control.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types and constants for the DIV/IDIV sequencing control.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_RANGE  = 3'd4,
    S_FINISH = 3'd5
  } div_state_e;

  // Total ce-cycles from request acceptance to FINISH when latency is fixed.
  localparam int unsigned DIV_LAT_BYTE = 16;
  localparam int unsigned DIV_LAT_WORD = 24;

  localparam logic        [31:0] UBYTE_MAX = 32'h0000_00FF;
  localparam logic        [31:0] UWORD_MAX = 32'h0000_FFFF;
  localparam logic signed [31:0] SBYTE_MIN = -32'sd128;
  localparam logic signed [31:0] SBYTE_MAX =  32'sd127;
  localparam logic signed [31:0] SWORD_MIN = -32'sd32768;
  localparam logic signed [31:0] SWORD_MAX =  32'sd32767;

endpackage

`default_nettype wire

// File: rtl/div_range_check.sv
// ============================================================================
// Module  : div_range_check
// Purpose : Combinational test of a 32-bit divider quotient against the
//           destination register range for byte/word, signed/unsigned ops.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_range_check
  import div_pkg::*;
(
  input  logic [31:0] quot_i,
  input  logic        wide_i,
  input  logic        signed_i,
  output logic        out_of_range_o
);

  logic signed [31:0] squot;
  assign squot = $signed(quot_i);

  always_comb begin
    out_of_range_o = 1'b0;
    case ({signed_i, wide_i})
      2'b00:   out_of_range_o = (quot_i > UBYTE_MAX);
      2'b01:   out_of_range_o = (quot_i > UWORD_MAX);
      2'b10:   out_of_range_o = (squot < SBYTE_MIN) || (squot > SBYTE_MAX);
      default: out_of_range_o = (squot < SWORD_MIN) || (squot > SWORD_MAX);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/div_control.sv
// ============================================================================
// Module  : div_control
// Purpose : Sequences one DIV/IDIV through an external divider: operand
//           extension, divide-by-zero and quotient range errors, result hold.
//           Optional macro DIV_FIXED_LATENCY_EN pads every op to a fixed
//           ce-cycle latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_control
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req,
  input  logic        op_wide,
  input  logic        op_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        div_start,
  output logic        div_wide,
  output logic        div_signed,
  output logic [31:0] div_num,
  output logic [31:0] div_denom,
  input  logic        div_done,
  input  logic [31:0] div_quot,
  input  logic [31:0] div_rem,
  output logic        busy,
  output logic        done,
  output logic        div_error,
  output logic [15:0] quot,
  output logic [15:0] rem
);

  div_state_e  state_q, state_d;
  logic        err_q, err_d;
  logic        first_q, first_d;
  logic        wide_q, signed_q;
  logic [31:0] num_q, denom_q;
  logic [31:0] num_d, denom_d;
  logic [31:0] res_quot_q;
  logic [15:0] res_rem_q;
  logic [15:0] quot_q, rem_q;
  logic        range_err;
  logic        lat_ok;
  logic        capture;
  logic        commit;
  logic        unused_rem_hi;

  assign unused_rem_hi = ^div_rem[31:16];

  always_comb begin
    num_d = op_wide ? dividend
          : (op_signed ? {{16{dividend[15]}}, dividend[15:0]} : {16'h0000, dividend[15:0]});
    denom_d = op_wide
          ? (op_signed ? {{16{divisor[15]}}, divisor} : {16'h0000, divisor})
          : (op_signed ? {{24{divisor[7]}}, divisor[7:0]} : {24'h000000, divisor[7:0]});
  end

  div_range_check u_range (
    .quot_i         (res_quot_q),
    .wide_i         (wide_q),
    .signed_i       (signed_q),
    .out_of_range_o (range_err)
  );

`ifdef DIV_FIXED_LATENCY_EN
  logic [4:0] lat_cnt_q;
  logic [4:0] lat_tgt;

  // Counter is zero in CHECK, so FINISH is entered on the LAT-th ce edge after acceptance.
  assign lat_tgt = wide_q ? 5'(DIV_LAT_WORD - 1) : 5'(DIV_LAT_BYTE - 1);
  assign lat_ok  = (lat_cnt_q >= lat_tgt);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_cnt_q <= 5'd0;
    end else if (ce) begin
      if (state_q == S_IDLE) begin
        lat_cnt_q <= 5'd0;
      end else if (lat_cnt_q != 5'h1F) begin
        lat_cnt_q <= lat_cnt_q + 5'd1;
      end
    end
  end
`else
  assign lat_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_CHECK;
          err_d   = 1'b0;
        end
      end
      S_CHECK: begin
        if (denom_q == 32'd0) begin
          err_d = 1'b1;
          if (lat_ok) state_d = S_FINISH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        first_d = 1'b1;
      end
      S_WAIT: begin
        // The divider's done level is still high from the previous op for one cycle.
        first_d = 1'b0;
        if (!first_q && div_done) state_d = S_RANGE;
      end
      S_RANGE: begin
        err_d = range_err;
        if (lat_ok) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FINISH);
    div_error = (state_q == S_FINISH) && err_q;
    div_start = (state_q == S_ISSUE);
  end

  assign capture = (state_q == S_WAIT) && !first_q && div_done;
  assign commit  = (state_q == S_RANGE) && lat_ok && !range_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wide_q     <= 1'b0;
      signed_q   <= 1'b0;
      num_q      <= 32'd0;
      denom_q    <= 32'd0;
      res_quot_q <= 32'd0;
      res_rem_q  <= 16'd0;
      quot_q     <= 16'd0;
      rem_q      <= 16'd0;
    end else if (ce) begin
      if ((state_q == S_IDLE) && req) begin
        wide_q   <= op_wide;
        signed_q <= op_signed;
        num_q    <= num_d;
        denom_q  <= denom_d;
      end
      if (capture) begin
        res_quot_q <= div_quot;
        res_rem_q  <= div_rem[15:0];
      end
      if (commit) begin
        quot_q <= wide_q ? res_quot_q[15:0] : {8'h00, res_quot_q[7:0]};
        rem_q  <= wide_q ? res_rem_q        : {8'h00, res_rem_q[7:0]};
      end
    end
  end

  assign div_wide   = wide_q;
  assign div_signed = signed_q;
  assign div_num    = num_q;
  assign div_denom  = denom_q;
  assign quot       = quot_q;
  assign rem        = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_div_control.sv
// ============================================================================
// Module  : tb_div_control
// Purpose : Self-checking bench for div_control with a behavioural divider
//           and an arithmetic reference model of the expected results.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic        req;
  logic        op_wide;
  logic        op_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        div_start, div_wide, div_signed;
  logic [31:0] div_num, div_denom;
  logic        div_done = 1'b1;
  logic [31:0] div_quot = 32'hDEAD_BEEF;
  logic [31:0] div_rem  = 32'hCAFE_F00D;
  logic        busy, done, div_error;
  logic [15:0] quot, rem;

  int n_cmp = 0;
  int n_err = 0;

  int          n_start = 0;
  logic [31:0] mon_num, mon_denom;
  logic        mon_wide, mon_signed;
  int          dv_stage = 0;
  int          dv_cnt = 0;
  logic [31:0] dv_pq, dv_pr;

  logic [15:0] exp_q, exp_r;

  div_control dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .req        (req),
    .op_wide    (op_wide),
    .op_signed  (op_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_start  (div_start),
    .div_wide   (div_wide),
    .div_signed (div_signed),
    .div_num    (div_num),
    .div_denom  (div_denom),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .busy       (busy),
    .done       (done),
    .div_error  (div_error),
    .quot       (quot),
    .rem        (rem)
  );

  always #5 clk = ~clk;

  // Truncating divide as the external divider would return it.
  function automatic logic [63:0] ref_div(input logic [31:0] n, input logic [31:0] d, input logic s);
    longint a, b, q, r;
    a = s ? longint'($signed(n)) : longint'(n);
    b = s ? longint'($signed(d)) : longint'(d);
    if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
    q = a / b;
    r = a % b;
    return {q[31:0], r[31:0]};
  endfunction

  // Divider stand-in: done stays high one more ce-cycle after start, then drops.
  always @(posedge clk) begin
    if (ce && div_start) begin
      n_start    <= n_start + 1;
      mon_num    <= div_num;
      mon_denom  <= div_denom;
      mon_wide   <= div_wide;
      mon_signed <= div_signed;
      {dv_pq, dv_pr} <= ref_div(div_num, div_denom, div_signed);
      dv_cnt     <= $urandom_range(0, 3);
      dv_stage   <= 1;
    end else if (ce && dv_stage == 1) begin
      div_done <= 1'b0;
      dv_stage <= 2;
    end else if (ce && dv_stage == 2) begin
      if (dv_cnt == 0) begin
        div_done <= 1'b1;
        div_quot <= dv_pq;
        div_rem  <= dv_pr;
        dv_stage <= 0;
      end else begin
        dv_cnt <= dv_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: integer values of the operands, quotient limits by width/sign.
  task automatic model_op(input logic w, input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                          output logic err, output logic [31:0] en, output logic [31:0] ed,
                          output logic [15:0] mq, output logic [15:0] mr);
    longint nv, dv, qv, rv, hi, lo;
    logic [15:0] a16;
    logic [7:0]  d8;
    a16 = dvd[15:0];
    d8  = dvs[7:0];
    if (w) begin
      nv = s ? longint'($signed(dvd)) : longint'(dvd);
      dv = s ? longint'($signed(dvs)) : longint'(dvs);
    end else begin
      nv = s ? longint'($signed(a16)) : longint'(a16);
      dv = s ? longint'($signed(d8))  : longint'(d8);
    end
    en = nv[31:0];
    ed = dv[31:0];
    mq = 16'h0;
    mr = 16'h0;
    if (dv == 0) begin
      err = 1'b1;
    end else begin
      qv = nv / dv;
      rv = nv % dv;
      hi = w ? (s ? 32767 : 65535) : (s ? 127 : 255);
      lo = s ? -(hi + 1) : 0;
      err = (qv < lo) || (qv > hi);
      mq = w ? qv[15:0] : {8'h00, qv[7:0]};
      mr = w ? rv[15:0] : {8'h00, rv[7:0]};
    end
  endtask

  task automatic do_op(input logic w, input logic s, input logic [31:0] dvd, input logic [15:0] dvs,
                       input bit rand_ce, input int exp_lat, input bit extra_req, input bit stretch);
    logic        e_err;
    logic [31:0] en, ed;
    logic [15:0] mq, mr;
    int          n;
    int          st0;
    model_op(w, s, dvd, dvs, e_err, en, ed, mq, mr);
    if (!e_err) begin
      exp_q = mq;
      exp_r = mr;
    end
    st0 = n_start;
    @(negedge clk);
    ce = 1'b1; req = 1'b1; op_wide = w; op_signed = s; dividend = dvd; divisor = dvs;
    @(negedge clk);
    req = 1'b0;
    n = 1;
    check("busy_after_req", busy, 1'b1);
    while (!done && n < 300) begin
      if (rand_ce) ce = ($urandom_range(0, 3) != 0);
      if (extra_req && n == 3) begin
        req = 1'b1; op_wide = ~w; dividend = ~dvd; divisor = dvs + 16'd3;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    check("done_seen", done, 1'b1);
    if (!done) return;
    if (exp_lat > 0) check("latency", n, exp_lat);
    check("div_error", div_error, e_err);
    check("quot", quot, exp_q);
    check("rem", rem, exp_r);
    check("start_count", n_start - st0, (ed == 32'd0) ? 0 : 1);
    if (ed != 32'd0) begin
      check("div_num", mon_num, en);
      check("div_denom", mon_denom, ed);
      check("div_wide", mon_wide, w);
      check("div_signed", mon_signed, s);
    end
    if (stretch) begin
      ce = 1'b0;
      repeat (2) begin
        @(negedge clk);
        check("done_stretch", done, 1'b1);
        check("error_stretch", div_error, e_err);
      end
    end
    // A request in the FINISH cycle must not be taken.
    ce = 1'b1; req = 1'b1; dividend = 32'h0000_0010; divisor = 16'h0002;
    @(negedge clk);
    req = 1'b0;
    check("done_drop", done, 1'b0);
    check("busy_drop", busy, 1'b0);
    check("error_drop", div_error, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        rw, rs;
    logic [31:0] rdvd;
    logic [15:0] rdvs;
    reset_n = 1'b0; ce = 1'b0; req = 1'b0; op_wide = 1'b0; op_signed = 1'b0;
    dividend = 32'h0; divisor = 16'h0;
    exp_q = 16'h0; exp_r = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_error", div_error, 1'b0);
    check("rst_start", div_start, 1'b0);
    check("rst_wide", div_wide, 1'b0);
    check("rst_signed", div_signed, 1'b0);
    check("rst_num", div_num, 32'h0);
    check("rst_denom", div_denom, 32'h0);
    check("rst_quot", quot, 16'h0);
    check("rst_rem", rem, 16'h0);
    reset_n = 1'b1;
    ce = 1'b1;

    do_op(1'b1, 1'b0, 32'h0001_0000, 16'h0002, 1'b0, 0, 1'b0, 1'b0);
    check("d028_quot", quot, 16'h8000);
    do_op(1'b0, 1'b0, 32'h0000_0400, 16'h0002, 1'b0, 0, 1'b0, 1'b1);
    check("d029_hold", quot, 16'h8000);
    do_op(1'b0, 1'b1, 32'h0000_FF9C, 16'h0007, 1'b0, 0, 1'b0, 1'b0);
    check("d030_quot", quot, 16'h00F2);
    check("d030_rem", rem, 16'h00FE);
    do_op(1'b0, 1'b0, 32'h0000_1234, 16'hFF00, 1'b0, 2, 1'b0, 1'b0);
    do_op(1'b1, 1'b1, 32'h0000_1234, 16'h0000, 1'b0, 2, 1'b0, 1'b1);
    do_op(1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    check("d032_quot", quot, 16'h8000);
    do_op(1'b1, 1'b1, 32'h0000_8000, 16'h0001, 1'b0, 0, 1'b1, 1'b0);

    // Abort while the divider is busy.
    @(negedge clk);
    ce = 1'b1; req = 1'b1; op_wide = 1'b1; op_signed = 1'b0;
    dividend = 32'h0000_1234; divisor = 16'h0005;
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_quot", quot, 16'h0);
    check("abort_start", div_start, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q = 16'h0; exp_r = 16'h0;
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    do_op(1'b1, 1'b0, 32'h0000_0064, 16'h000A, 1'b0, 0, 1'b0, 1'b0);
    check("d033_quot", quot, 16'h000A);
    check("d033_rem", rem, 16'h0000);

    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      rdvd = $urandom >> $urandom_range(0, 31);
      if (rs && $urandom_range(0, 1) == 1) rdvd = -rdvd;
      rdvs = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom >> $urandom_range(0, 15));
      if (rs && $urandom_range(0, 3) == 0) rdvs = -rdvs;
      do_op(rw, rs, rdvd, rdvs, 1'b1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
